// File: rtl/macload_csr_bank.sv
// MAC-load pointer CSR bank: activation/weight address, stride, rollback and skip registers,
// updated by software CSR ops and by hardware address-update writes from the load controller.
module macload_csr_bank #(
    parameter logic [11:0] A_BASE = 12'h7D0,
    parameter logic [11:0] W_BASE = 12'h7D8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  sw_op_i,
    input  logic [11:0] sw_addr_i,
    input  logic [31:0] sw_wdata_i,
    output logic [31:0] sw_rdata_o,
    output logic        sw_hit_o,
    input  logic [1:0]  hw_op_i,
    input  logic [11:0] hw_addr_i,
    input  logic [31:0] hw_wdata_i,
    output logic [31:0] a_address_o,
    output logic [31:0] w_address_o,
    output logic [31:0] a_stride_o,
    output logic [31:0] w_stride_o,
    output logic [31:0] a_rollback_o,
    output logic [31:0] w_rollback_o,
    output logic [31:0] a_skip_o,
    output logic [31:0] w_skip_o,
    output logic        csr_a_rstn_o,
    output logic        csr_w_rstn_o,
    output logic        hw_drop_o
);

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    csr_op_e     sw_op;
    csr_op_e     hw_op;
    logic [31:0] regs [8];
    logic [11:0] a_off;
    logic [11:0] w_off;
    logic        hit_a;
    logic        hit_w;
    logic [2:0]  sw_idx;
    logic        sw_act;
    logic [31:0] sw_old;
    logic [31:0] sw_new;
    logic        hw_a;
    logic        hw_w;
    logic [2:0]  hw_idx;
    logic        hw_apply;
    logic        hw_drop_d;

    assign sw_op = csr_op_e'(sw_op_i);
    assign hw_op = csr_op_e'(hw_op_i);

    // Index layout: 0..3 = A_ADDR/STRIDE/ROLLBACK/SKIP, 4..7 = the W_* counterparts.
    assign a_off  = sw_addr_i - A_BASE;
    assign w_off  = sw_addr_i - W_BASE;
    assign hit_a  = (a_off < 12'd4);
    assign hit_w  = (w_off < 12'd4);
    assign sw_idx = hit_a ? {1'b0, a_off[1:0]} : {1'b1, w_off[1:0]};

    assign sw_hit_o   = hit_a | hit_w;
    assign sw_rdata_o = sw_hit_o ? regs[sw_idx] : '0;

    always_comb begin
        sw_act = sw_hit_o && (sw_op != OP_NONE);
        sw_old = regs[sw_idx];
        sw_new = sw_old;
        unique case (sw_op)
            OP_WRITE: sw_new = sw_wdata_i;
            OP_SET:   sw_new = sw_old | sw_wdata_i;
            OP_CLEAR: sw_new = sw_old & ~sw_wdata_i;
            default:  sw_new = sw_old;
        endcase
    end

    // A hardware write loses to a software op on the same register in the same cycle.
    always_comb begin
        hw_a      = (hw_op == OP_WRITE) && (hw_addr_i == A_BASE);
        hw_w      = (hw_op == OP_WRITE) && (hw_addr_i == W_BASE);
        hw_idx    = hw_w ? 3'd4 : 3'd0;
        hw_apply  = (hw_a || hw_w) && !(sw_act && (sw_idx == hw_idx));
        hw_drop_d = (hw_op != OP_NONE) && !hw_apply;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs         <= '{default: '0};
            csr_a_rstn_o <= 1'b1;
            csr_w_rstn_o <= 1'b1;
            hw_drop_o    <= 1'b0;
        end else begin
            if (hw_apply) begin
                regs[hw_idx] <= hw_wdata_i;
            end
            if (sw_act) begin
                regs[sw_idx] <= sw_new;
            end
            csr_a_rstn_o <= !(sw_act && !sw_idx[2]);
            csr_w_rstn_o <= !(sw_act && sw_idx[2]);
            hw_drop_o    <= hw_drop_d;
        end
    end

    assign a_address_o  = regs[0];
    assign a_stride_o   = regs[1];
    assign a_rollback_o = regs[2];
    assign a_skip_o     = regs[3];
    assign w_address_o  = regs[4];
    assign w_stride_o   = regs[5];
    assign w_rollback_o = regs[6];
    assign w_skip_o     = regs[7];

endmodule
